nlm_linebuf_sched: RTL and testbench

- Sequences the (2*WIN_RADIUS+1) simple dual-port line SRAMs that feed the NLM block-matching window in the RAWDNS path.
- Accepts a raster pixel stream and steers each pixel to the correct line SRAM as a rotating one-hot write.
- Issues column-synchronous reads across all lines and tags each returned column with its window-centre coordinates.
- Handles the fill phase at frame start and the flush phase at frame end; the NLM process stage consumes its outputs.

---
 rtl/nlm_linebuf_sched_if.sv | 35 +++
 rtl/nlm_linebuf_sched.sv | 128 ++++++++++++
 tb/tb_nlm_linebuf_sched.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/nlm_linebuf_sched_if.sv
// Pixel handshake, line-SRAM access and window-tag signals of the NLM line buffer scheduler.
// master = scheduler side, slave = stream source / SRAM / NLM stage side.
interface nlm_linebuf_sched_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int ROW_WIDTH  = 12,
  parameter int WIN_RADIUS = 2
);
  localparam int NL = 2 * WIN_RADIUS + 1;
  localparam int LW = $clog2(NL);

  logic                  pix_valid_i;
  logic                  pix_ready_o;
  logic [NL-1:0]         wren_to_sram_o;
  logic [ADDR_WIDTH-1:0] wraddr_to_sram_o;
  logic                  rden_from_sram_o;
  logic [ADDR_WIDTH-1:0] rdaddr_from_sram_o;
  logic                  win_valid_o;
  logic [ROW_WIDTH-1:0]  win_row_o;
  logic [ADDR_WIDTH-1:0] win_col_o;
  logic [LW-1:0]         center_line_o;

  modport master (
    input  pix_valid_i,
    output pix_ready_o, wren_to_sram_o, wraddr_to_sram_o,
           rden_from_sram_o, rdaddr_from_sram_o,
           win_valid_o, win_row_o, win_col_o, center_line_o
  );

  modport slave (
    output pix_valid_i,
    input  pix_ready_o, wren_to_sram_o, wraddr_to_sram_o,
           rden_from_sram_o, rdaddr_from_sram_o,
           win_valid_o, win_row_o, win_col_o, center_line_o
  );
endinterface

// File: rtl/nlm_linebuf_sched.sv
// Line-SRAM sequencer for the NLM window: rotating one-hot writes, column-synchronous
// reads across all lines, and window-centre tagging through fill, run and flush phases.
module nlm_linebuf_sched #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 12,
  parameter int IMAGE_WIDTH  = 4032,
  parameter int IMAGE_HEIGHT = 3024,
  parameter int WIN_RADIUS   = 2,
  parameter int ROW_WIDTH    = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                frame_start_i,
  nlm_linebuf_sched_if.master bus,
  output logic                busy_o,
  output logic                frame_done_o
);
  localparam int NL = 2 * WIN_RADIUS + 1;
  localparam int LW = $clog2(NL);

  localparam logic [ADDR_WIDTH-1:0] COL_LAST       = ADDR_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [ROW_WIDTH-1:0]  ROW_FILL_LAST  = ROW_WIDTH'(WIN_RADIUS - 1);
  localparam logic [ROW_WIDTH-1:0]  ROW_RUN_LAST   = ROW_WIDTH'(IMAGE_HEIGHT - 1);
  localparam logic [ROW_WIDTH-1:0]  ROW_FLUSH_LAST = ROW_WIDTH'(IMAGE_HEIGHT + WIN_RADIUS - 1);
  localparam logic [ROW_WIDTH-1:0]  ROW_R          = ROW_WIDTH'(WIN_RADIUS);
  localparam logic [LW-1:0]         LINE_LAST      = LW'(NL - 1);
  localparam logic [LW:0]           CTR_OFF        = (LW + 1)'(NL - WIN_RADIUS);
  localparam logic [LW:0]           NL_EXT         = (LW + 1)'(NL);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] col;
  logic [ROW_WIDTH-1:0]  in_row;
  logic [LW-1:0]         wr_line;
  logic                  pix_ready, accept, rd_issue, last_read, start;
  logic [LW:0]           ctr_sum;
  logic [LW-1:0]         center_next;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pix_ready  = 1'b0;
    accept     = 1'b0;
    rd_issue   = 1'b0;
    last_read  = 1'b0;
    start      = 1'b0;
    unique case (state)
      IDLE: begin
        start = frame_start_i && en_i;
        if (start) state_next = FILL;
      end
      FILL: begin
        pix_ready = en_i;
        accept    = pix_ready && bus.pix_valid_i;
        if (accept && in_row == ROW_FILL_LAST && col == COL_LAST) state_next = RUN;
      end
      RUN: begin
        pix_ready = en_i;
        accept    = pix_ready && bus.pix_valid_i;
        rd_issue  = accept;
        if (accept && in_row == ROW_RUN_LAST && col == COL_LAST) state_next = FLUSH;
      end
      FLUSH: begin
        rd_issue  = en_i;
        last_read = en_i && in_row == ROW_FLUSH_LAST && col == COL_LAST;
        if (last_read) state_next = DONE;
      end
      DONE: if (en_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // wr_line equals in_row mod NL, so the centre line sits R lines behind it.
  always_comb begin
    ctr_sum     = {1'b0, wr_line} + CTR_OFF;
    center_next = (ctr_sum >= NL_EXT) ? LW'(ctr_sum - NL_EXT) : LW'(ctr_sum);
  end

  assign bus.pix_ready_o        = pix_ready;
  assign bus.wren_to_sram_o     = accept ? (NL'(1) << wr_line) : '0;
  assign bus.wraddr_to_sram_o   = accept ? col : '0;
  assign bus.rden_from_sram_o   = rd_issue;
  assign bus.rdaddr_from_sram_o = rd_issue ? col : '0;
  assign busy_o                 = (state != IDLE);

  // wr_line keeps rotating through FLUSH so the centre-line derivation stays valid there.
  always_ff @(posedge clk) begin
    if (rst) begin
      col               <= '0;
      in_row            <= '0;
      wr_line           <= '0;
      bus.win_valid_o   <= 1'b0;
      bus.win_row_o     <= '0;
      bus.win_col_o     <= '0;
      bus.center_line_o <= '0;
      frame_done_o      <= 1'b0;
    end else begin
      bus.win_valid_o <= rd_issue;
      frame_done_o    <= last_read;
      if (rd_issue) begin
        bus.win_row_o     <= in_row - ROW_R;
        bus.win_col_o     <= col;
        bus.center_line_o <= center_next;
      end
      if (start) begin
        col     <= '0;
        in_row  <= '0;
        wr_line <= '0;
      end else if (accept || rd_issue) begin
        if (col == COL_LAST) begin
          col <= '0;
          if (!last_read) begin
            in_row  <= in_row + ROW_WIDTH'(1);
            wr_line <= (wr_line == LINE_LAST) ? '0 : wr_line + LW'(1);
          end
        end else begin
          col <= col + ADDR_WIDTH'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_nlm_linebuf_sched.sv
// Directed bench for nlm_linebuf_sched at W=8, H=6, R=2 (five lines).
module tb_nlm_linebuf_sched;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int R  = 2;
  localparam int NL = 2 * R + 1;
  localparam int AW = 4;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic frame_start = 1'b0;
  logic busy, frame_done;

  int checks = 0;
  int errors = 0;
  int win_cnt, done_cnt, exp_r, exp_c;

  always #5 clk = ~clk;

  nlm_linebuf_sched_if #(.ADDR_WIDTH(AW), .ROW_WIDTH(RW), .WIN_RADIUS(R)) bus ();

  nlm_linebuf_sched #(
    .DATA_WIDTH(16), .ADDR_WIDTH(AW), .IMAGE_WIDTH(W),
    .IMAGE_HEIGHT(H), .WIN_RADIUS(R), .ROW_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en), .frame_start_i(frame_start),
    .bus(bus), .busy_o(busy), .frame_done_o(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check any window tag against the raster order expected next.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (bus.win_valid_o) begin
      chk("win_row", bus.win_row_o, exp_r);
      chk("win_col", bus.win_col_o, exp_c);
      chk("center_line", bus.center_line_o, exp_r % NL);
      win_cnt++;
      if (exp_c == W - 1) begin
        exp_c = 0;
        exp_r++;
      end else begin
        exp_c++;
      end
    end
    if (frame_done) begin
      chk("done_tag", {bus.win_valid_o, bus.win_row_o, bus.win_col_o}, {1'b1, 4'd5, 4'd7});
      done_cnt++;
    end
  endtask

  task automatic new_frame_model();
    win_cnt  = 0;
    done_cnt = 0;
    exp_r    = 0;
    exp_c    = 0;
  endtask

  task automatic run_frame(input bit toggle, input bit start_in_run, input bit en_gap);
    int p, k, rd, gap;
    bit v;
    new_frame_model();
    en          = 1'b1;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    chk("busy_fill", busy, 1);
    p = 0;
    k = 0;
    while (p < W * H && k < 400) begin
      v = (toggle && p >= R * W) ? k[0] : 1'b1;
      bus.pix_valid_i = v;
      frame_start     = start_in_run && (p == 20);
      #1;
      chk("pix_ready", bus.pix_ready_o, 1);
      chk("wren", bus.wren_to_sram_o, v ? (32'd1 << ((p / W) % NL)) : 32'd0);
      if (v) chk("wraddr", bus.wraddr_to_sram_o, p % W);
      chk("rden", bus.rden_from_sram_o, v && p >= R * W);
      if (v && p >= R * W) chk("rdaddr", bus.rdaddr_from_sram_o, p % W);
      cyc();
      if (v) p++;
      k++;
      if (v && p == R * W + 1) chk("first_win", win_cnt, 1);
    end
    chk("pix_count", p, W * H);
    bus.pix_valid_i = 1'b0;
    frame_start     = 1'b0;
    chk("run_wins", win_cnt, (H - R) * W);
    rd  = 0;
    gap = 0;
    k   = 0;
    while (rd < R * W && k < 60) begin
      if (en_gap && rd == 3 && gap < 3) begin
        en = 1'b0;
        #1;
        chk("gap_rden", bus.rden_from_sram_o, 0);
        chk("gap_ready", bus.pix_ready_o, 0);
        chk("gap_busy", busy, 1);
        cyc();
        chk("gap_win_valid", bus.win_valid_o, 0);
        gap++;
      end else begin
        en = 1'b1;
        #1;
        chk("flush_ready", bus.pix_ready_o, 0);
        chk("flush_wren", bus.wren_to_sram_o, 0);
        chk("flush_rden", bus.rden_from_sram_o, 1);
        chk("flush_rdaddr", bus.rdaddr_from_sram_o, rd % W);
        cyc();
        rd++;
      end
      k++;
    end
    en = 1'b1;
    chk("flush_reads", rd, R * W);
    if (en_gap) chk("gap_len", gap, 3);
    chk("done_pulse", done_cnt, 1);
    chk("total_wins", win_cnt, W * H);
    chk("busy_in_done", busy, 1);
    cyc();
    chk("busy_idle", busy, 0);
    chk("done_low", frame_done, 0);
    chk("done_single", done_cnt, 1);
  endtask

  initial begin
    bus.pix_valid_i = 1'b0;
    new_frame_model();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.pix_ready_o, 0);
    chk("rst_wren", bus.wren_to_sram_o, 0);
    chk("rst_rden", bus.rden_from_sram_o, 0);
    chk("rst_win_valid", bus.win_valid_o, 0);
    chk("rst_win_row", bus.win_row_o, 0);
    chk("rst_win_col", bus.win_col_o, 0);
    chk("rst_center", bus.center_line_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    rst = 1'b0;
    cyc();

    run_frame(1'b0, 1'b0, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b1);

    // Abort mid-frame at row 3, col 4.
    new_frame_model();
    frame_start = 1'b1;
    cyc();
    frame_start     = 1'b0;
    bus.pix_valid_i = 1'b1;
    for (int i = 0; i < 3 * W + 4; i++) cyc();
    rst             = 1'b1;
    bus.pix_valid_i = 1'b0;
    cyc();
    chk("abort_ready", bus.pix_ready_o, 0);
    chk("abort_wren", bus.wren_to_sram_o, 0);
    chk("abort_rden", bus.rden_from_sram_o, 0);
    chk("abort_win_valid", bus.win_valid_o, 0);
    chk("abort_win_row", bus.win_row_o, 0);
    chk("abort_win_col", bus.win_col_o, 0);
    chk("abort_center", bus.center_line_o, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    repeat (3) cyc();
    chk("abort_no_done", done_cnt, 0);

    run_frame(1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
